// File: rtl/riscv_memory_responder_pkg.sv
// Shared types and constants for the cache<->memory word responder.
// Holds the FSM state encoding, the word width and a word-alignment helper.
package riscv_memory_responder_pkg;

    localparam int MEM_WORD_BITS = 32;

    typedef enum logic [1:0] {
        MEMR_IDLE    = 2'd0,
        MEMR_WAIT    = 2'd1,
        MEMR_RESPOND = 2'd2
    } memr_state_e;

    function automatic logic [MEM_WORD_BITS-1:0] word_align(input logic [MEM_WORD_BITS-1:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/riscv_memory_responder_if.sv
// Cache<->memory word request/response bundle; master = cache side, slave = memory side.
interface riscv_memory_responder_if;
    import riscv_memory_responder_pkg::*;

    logic [MEM_WORD_BITS-1:0] mem_address;
    logic                     mem_read;
    logic                     mem_write;
    logic [MEM_WORD_BITS-1:0] mem_wdata;
    logic [MEM_WORD_BITS-1:0] mem_rdata;
    logic                     mem_ready;
    logic [MEM_WORD_BITS-1:0] mem_address_requested;

    modport master (
        output mem_address, mem_read, mem_write, mem_wdata,
        input  mem_rdata, mem_ready, mem_address_requested
    );

    modport slave (
        input  mem_address, mem_read, mem_write, mem_wdata,
        output mem_rdata, mem_ready, mem_address_requested
    );
endinterface

// File: rtl/riscv_memory_responder_ram_array.sv
// Word RAM: synchronous write, asynchronous read on a separate read index.
// No backpressure; a write lands at the clock edge it is presented on.
module riscv_ram_array #(
    parameter int DEPTH_WORDS = 4096,
    parameter int WIDTH       = 32,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clock,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/riscv_memory_responder.sv
// Memory-side responder: reads answered LATENCY cycles after acceptance, writes acked next cycle.
// No stall path to the cache; a write ack colliding with a due read delays the read by one cycle.
module riscv_memory_responder
    import riscv_memory_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    riscv_memory_responder_if.slave  mem
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    memr_state_e              state_q;
    logic [3:0]               cnt_q;
    logic [MEM_WORD_BITS-1:0] rd_addr_q;
    logic                     rd_owed_q;
    logic                     ready_q;
    logic [MEM_WORD_BITS-1:0] rdata_q;
    logic [MEM_WORD_BITS-1:0] addr_req_q;

    logic                     rd_due;
    logic [MEM_WORD_BITS-1:0] rd_resp_addr;
    logic [IDX_W-1:0]         ram_raddr;
    logic [MEM_WORD_BITS-1:0] ram_rdata;

    // In IDLE with LATENCY=1 the response comes from the address being accepted right now.
    assign rd_resp_addr = (state_q == MEMR_IDLE) ? word_align(mem.mem_address) : rd_addr_q;
    assign ram_raddr    = rd_resp_addr[2 +: IDX_W];

    assign rd_due = ((state_q == MEMR_IDLE) && mem.mem_read && (LATENCY == 1))
                 || ((state_q == MEMR_WAIT) && (cnt_q == 4'd1))
                 || ((state_q == MEMR_RESPOND) && rd_owed_q);

    riscv_ram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .WIDTH       (MEM_WORD_BITS)
    ) u_ram (
        .clock   (clock),
        .we_i    (mem.mem_write && !reset),
        .waddr_i (mem.mem_address[2 +: IDX_W]),
        .wdata_i (mem.mem_wdata),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= MEMR_IDLE;
            cnt_q      <= 4'd0;
            rd_addr_q  <= '0;
            rd_owed_q  <= 1'b0;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            addr_req_q <= '0;
        end else begin
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            addr_req_q <= '0;
            // Write acks take the single completion slot; a due read stays owed until free.
            if (mem.mem_write) begin
                ready_q    <= 1'b1;
                addr_req_q <= word_align(mem.mem_address);
            end else if (rd_due) begin
                ready_q    <= 1'b1;
                rdata_q    <= ram_rdata;
                addr_req_q <= rd_resp_addr;
            end

            case (state_q)
                MEMR_IDLE: begin
                    if (mem.mem_read) begin
                        rd_addr_q <= word_align(mem.mem_address);
                        if (LATENCY == 1) begin
                            state_q   <= MEMR_RESPOND;
                            rd_owed_q <= mem.mem_write;
                        end else begin
                            state_q <= MEMR_WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                MEMR_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q   <= MEMR_RESPOND;
                        rd_owed_q <= mem.mem_write;
                    end
                end
                MEMR_RESPOND: begin
                    if (rd_owed_q) begin
                        rd_owed_q <= mem.mem_write;
                    end else begin
                        state_q <= MEMR_IDLE;
                    end
                end
                default: state_q <= MEMR_IDLE;
            endcase
        end
    end

    assign mem.mem_ready             = ready_q;
    assign mem.mem_rdata             = rdata_q;
    assign mem.mem_address_requested = addr_req_q;

endmodule

// File: tb/tb_riscv_memory_responder.sv
// Bench for riscv_memory_responder: directed vectors, literal expectations and a
// per-cycle reference model of pending reads, write acks and memory contents.
module tb_riscv_memory_responder;

    localparam int DEPTH = 4096;
    localparam int LAT   = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;

    riscv_memory_responder_if bus();

    riscv_memory_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .mem   (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model: memory by word index, one outstanding read with its due cycle.
    logic [31:0] mdl_mem [int];
    int          cyc       = 0;
    bit          mdl_valid = 0;
    bit          has_rd    = 0;
    logic [31:0] rd_a      = '0;
    int          rd_due    = 0;
    int          next_acc  = 0;
    logic        e_rdy     = 0;
    logic [31:0] e_dat     = '0;
    logic [31:0] e_adr     = '0;

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    always @(posedge clock) begin
        cyc++;
        mdl_valid = 1;
        e_rdy = 0;
        e_dat = '0;
        e_adr = '0;
        if (reset) begin
            has_rd   = 0;
            next_acc = cyc + 1;
        end else begin
            if (bus.mem_read && !has_rd && cyc >= next_acc) begin
                has_rd = 1;
                rd_a   = bus.mem_address & ~32'h3;
                rd_due = cyc + LAT;
            end
            if (bus.mem_write) begin
                e_rdy = 1;
                e_adr = bus.mem_address & ~32'h3;
            end else if (has_rd && rd_due <= cyc + 1) begin
                e_rdy    = 1;
                e_adr    = rd_a;
                e_dat    = mdl_mem.exists(widx(rd_a)) ? mdl_mem[widx(rd_a)] : 32'h0;
                has_rd   = 0;
                next_acc = cyc + 2;
            end
            if (bus.mem_write) mdl_mem[widx(bus.mem_address)] = bus.mem_wdata;
        end
    end

    always @(negedge clock) begin
        if (mdl_valid) begin
            checks++;
            if (bus.mem_ready !== e_rdy || bus.mem_rdata !== e_dat ||
                (e_rdy && bus.mem_address_requested !== e_adr)) begin
                failures++;
                $display("FAIL model cycle %0d: got ready=%0b rdata=%h addr=%h, required ready=%0b rdata=%h addr=%h",
                         cyc, bus.mem_ready, bus.mem_rdata, bus.mem_address_requested, e_rdy, e_dat, e_adr);
            end
        end
    end

    task automatic step(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic rst = 1'b0);
        reset           = rst;
        bus.mem_read    = rd;
        bus.mem_write   = wr;
        bus.mem_address = a;
        bus.mem_wdata   = d;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic lit(input string name, input logic r, input logic [31:0] d, input logic [31:0] a);
        checks++;
        if (bus.mem_ready !== r || bus.mem_rdata !== d || (r && bus.mem_address_requested !== a)) begin
            failures++;
            $display("FAIL %s: got ready=%0b rdata=%h addr=%h, required ready=%0b rdata=%h addr=%h",
                     name, bus.mem_ready, bus.mem_rdata, bus.mem_address_requested, r, d, a);
        end
    endtask

    initial begin
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_address = '0;
        bus.mem_wdata   = '0;
        repeat (3) @(negedge clock);

        // Quiet after reset: nothing completes, outputs held at zero.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 32'h0, 32'h0);
            lit("reset_idle", 1'b0, 32'h0, 32'h0);
        end

        // Write ack next cycle, then a held read answered once at acceptance+2.
        step(1'b0, 1'b1, 32'h100, 32'hDEADBEEF);   lit("wr_ack", 1'b1, 32'h0, 32'h100);
        idle(2);                                   lit("wr_ack_single", 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 32'h100, 32'h0);          lit("rd_wait", 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 32'h100, 32'h0);          lit("rd_resp", 1'b1, 32'hDEADBEEF, 32'h100);
        step(1'b1, 1'b0, 32'h100, 32'h0);          lit("rd_one_pulse", 1'b0, 32'h0, 32'h0);
        idle(2);

        // Low address bits ignored; upper bits echoed but index wraps.
        step(1'b0, 1'b1, 32'h203, 32'hA5A50200);   lit("wr_ack_align", 1'b1, 32'h0, 32'h200);
        step(1'b0, 1'b1, 32'h204, 32'h02045A5A);
        step(1'b0, 1'b1, 32'h300, 32'h00000011);
        idle(1);
        step(1'b1, 1'b0, 32'h80004103, 32'h0);
        step(1'b1, 1'b0, 32'h80004103, 32'h0);     lit("rd_upper_echo", 1'b1, 32'hDEADBEEF, 32'h80004100);
        idle(2);

        // Address change while waiting does not cancel; new address accepted after response.
        step(1'b1, 1'b0, 32'h200, 32'h0);
        step(1'b1, 1'b0, 32'h204, 32'h0);          lit("rd_addr_held", 1'b1, 32'hA5A50200, 32'h200);
        step(1'b1, 1'b0, 32'h204, 32'h0);          lit("rd_respond_gap", 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 32'h204, 32'h0);
        step(1'b1, 1'b0, 32'h204, 32'h0);          lit("rd_second", 1'b1, 32'h02045A5A, 32'h204);
        idle(2);

        // Write ack collides with the due read; read follows with the new data.
        step(1'b1, 1'b0, 32'h300, 32'h0);
        step(1'b1, 1'b1, 32'h300, 32'h00000022);   lit("coll_wr_ack", 1'b1, 32'h0, 32'h300);
        step(1'b1, 1'b0, 32'h300, 32'h0);          lit("coll_rd_late", 1'b1, 32'h00000022, 32'h300);
        idle(1);                                   lit("coll_done", 1'b0, 32'h0, 32'h0);
        idle(1);

        // Simultaneous write and read in IDLE: write first, read sees it.
        step(1'b1, 1'b1, 32'h400, 32'h00000077);   lit("rw_same_ack", 1'b1, 32'h0, 32'h400);
        step(1'b1, 1'b0, 32'h400, 32'h0);          lit("rw_same_rd", 1'b1, 32'h00000077, 32'h400);
        idle(2);

        // Depth wrap: 0x4000 aliases word 0.
        step(1'b0, 1'b1, 32'h4000, 32'h00000005);  lit("wrap_ack", 1'b1, 32'h0, 32'h4000);
        step(1'b1, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 32'h0, 32'h0);            lit("wrap_rd", 1'b1, 32'h00000005, 32'h0);
        idle(2);

        // Reset mid-read abandons it; the next read is served normally.
        step(1'b1, 1'b0, 32'h100, 32'h0);
        step(1'b0, 1'b0, 32'h100, 32'h0, 1'b1);    lit("rst_abandon", 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 32'h204, 32'h0);          lit("rst_quiet", 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 32'h204, 32'h0);          lit("rst_new_rd", 1'b1, 32'h02045A5A, 32'h204);
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
